// File: rtl/general_register_pkg.sv
// Shared types and select-decode helpers for the w80386dx general register file.
// A register select is a 24-bit one-hot bundle covering AL..BH, AX..DI and EAX..EDI.
package general_register_pkg;

  localparam int DATA_W  = 32;
  localparam int NUM_GPR = 8;

  localparam logic [2:0] EAX = 3'd0;
  localparam logic [2:0] ECX = 3'd1;
  localparam logic [2:0] EDX = 3'd2;
  localparam logic [2:0] EBX = 3'd3;
  localparam logic [2:0] ESP = 3'd4;
  localparam logic [2:0] EBP = 3'd5;
  localparam logic [2:0] ESI = 3'd6;
  localparam logic [2:0] EDI = 3'd7;

  typedef struct packed {
    logic [7:0] byte_sel;
    logic [7:0] word_sel;
    logic [7:0] dword_sel;
  } reg_select_t;

  typedef enum logic [1:0] {
    LANE_LO8,
    LANE_HI8,
    LANE_W16,
    LANE_D32
  } lane_t;

  function automatic logic sel_is_onehot(input reg_select_t sel);
    logic [23:0] bits;
    bits = sel;
    return $countones(bits) == 1;
  endfunction

  // Byte selects 4..7 are AH..BH, which live in bits [15:8] of GPR 0..3.
  function automatic logic [2:0] sel_to_index(input reg_select_t sel);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (sel.dword_sel[i] || sel.word_sel[i]) idx = 3'(i);
      if (sel.byte_sel[i]) idx = {1'b0, 2'(i)};
    end
    return idx;
  endfunction

  function automatic lane_t sel_to_lane(input reg_select_t sel);
    if (|sel.byte_sel) return (|sel.byte_sel[7:4]) ? LANE_HI8 : LANE_LO8;
    if (|sel.word_sel) return LANE_W16;
    return LANE_D32;
  endfunction

  function automatic logic [DATA_W-1:0] lane_merge(input logic [DATA_W-1:0] old,
                                                   input lane_t lane,
                                                   input logic [DATA_W-1:0] data);
    case (lane)
      LANE_LO8: return {old[31:8], data[7:0]};
      LANE_HI8: return {old[31:16], data[7:0], old[7:0]};
      LANE_W16: return {old[31:16], data[15:0]};
      default:  return data;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] lane_extract(input logic [DATA_W-1:0] src,
                                                     input lane_t lane);
    case (lane)
      LANE_LO8: return {24'd0, src[7:0]};
      LANE_HI8: return {24'd0, src[15:8]};
      LANE_W16: return {16'd0, src[15:0]};
      default:  return src;
    endcase
  endfunction

endpackage

// File: rtl/general_register_read_port.sv
// One registered read port: select decode, same-cycle write bypass, zero-extension.
// An invalid select still produces a response, with zero data.
module general_register_read_port
  import general_register_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           rd_valid,
  input  reg_select_t                    rd_sel,
  input  logic [NUM_GPR-1:0][DATA_W-1:0] gpr,
  input  logic                           wr_en,
  input  logic [2:0]                     wr_idx,
  input  logic [DATA_W-1:0]              wr_value,
  output logic                           rd_data_valid,
  output logic [DATA_W-1:0]              rd_data,
  output logic                           rd_sel_error
);

  logic              onehot_p0;
  logic [2:0]        idx_p0;
  lane_t             lane_p0;
  logic [DATA_W-1:0] src_p0;
  logic [DATA_W-1:0] data_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;

  // Stage p0: decode and bypass against the write landing this same edge
  always_comb begin
    onehot_p0 = sel_is_onehot(rd_sel);
    idx_p0    = sel_to_index(rd_sel);
    lane_p0   = sel_to_lane(rd_sel);
    src_p0    = (wr_en && (wr_idx == idx_p0)) ? wr_value : gpr[idx_p0];
    data_p0   = onehot_p0 ? lane_extract(src_p0, lane_p0) : '0;
  end

  assign rd_sel_error = rd_valid & ~onehot_p0;

  // Stage p1: response register; data holds while no request is pending
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= rd_valid;
      if (rd_valid) data_p1 <= data_p0;
    end
  end

  assign rd_data_valid = vld_p1;
  assign rd_data       = data_p1;

endmodule

// File: rtl/general_register_file.sv
// Architectural GPR storage (EAX..EDI): one lane-masked write port and
// READ_PORTS registered read ports with write-to-read bypass and select checking.
module general_register_file
  import general_register_pkg::*;
#(
  parameter logic [31:0] RESET_EDX  = 32'h0000_0303,
  parameter int          READ_PORTS = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  reg_select_t                        wr_sel,
  input  logic [DATA_W-1:0]                  wr_data,
  input  logic [READ_PORTS-1:0]              rd_valid,
  input  reg_select_t [READ_PORTS-1:0]       rd_sel,
  output logic [READ_PORTS-1:0]              rd_data_valid,
  output logic [READ_PORTS-1:0][DATA_W-1:0]  rd_data,
  output logic                               select_error
);

  logic [NUM_GPR-1:0][DATA_W-1:0] gpr_q;
  logic                           ready_q;
  logic                           err_q;

  logic              wr_accept;
  logic              wr_onehot;
  logic              wr_en;
  logic [2:0]        wr_idx;
  logic [DATA_W-1:0] wr_value;
  logic [READ_PORTS-1:0] rd_err;

  // Masking with reset keeps a write issued in a reset cycle from landing
  assign wr_ready = ready_q & ~reset;

  // Stage p0: write decode and lane merge into the addressed GPR
  always_comb begin
    wr_accept = wr_valid & wr_ready;
    wr_onehot = sel_is_onehot(wr_sel);
    wr_en     = wr_accept & wr_onehot;
    wr_idx    = sel_to_index(wr_sel);
    wr_value  = lane_merge(gpr_q[wr_idx], sel_to_lane(wr_sel), wr_data);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_GPR; i++)
        gpr_q[i] <= (i == int'(EDX)) ? RESET_EDX : '0;
    end else begin
      ready_q <= 1'b1;
      err_q   <= (wr_accept & ~wr_onehot) | (|rd_err);
      if (wr_en) gpr_q[wr_idx] <= wr_value;
    end
  end

  assign select_error = err_q;

  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    general_register_read_port u_port (
      .clock         (clock),
      .reset         (reset),
      .rd_valid      (rd_valid[p]),
      .rd_sel        (rd_sel[p]),
      .gpr           (gpr_q),
      .wr_en         (wr_en),
      .wr_idx        (wr_idx),
      .wr_value      (wr_value),
      .rd_data_valid (rd_data_valid[p]),
      .rd_data       (rd_data[p]),
      .rd_sel_error  (rd_err[p])
    );
  end

endmodule

// File: tb/tb_general_register_file.sv
// Self-checking bench for general_register_file: directed scenarios plus random
// traffic, compared every cycle against a register-array model of the GPRs.
module tb_general_register_file;
  import general_register_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  reg_select_t       wr_sel = '0;
  logic [31:0]       wr_data = '0;
  logic [1:0]        rd_valid = '0;
  reg_select_t [1:0] rd_sel = '0;
  logic [1:0]        rd_data_valid;
  logic [1:0][31:0]  rd_data;
  logic              select_error;

  int total = 0;
  int bad   = 0;

  general_register_file #(.RESET_EDX(32'h0000_0303), .READ_PORTS(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_sel        (wr_sel),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_sel        (rd_sel),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .select_error  (select_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: select bit k -> dword k (0..7), word k-8 (8..15), byte k-16 (16..23)
  logic [31:0] m [8];
  logic [1:0]  exp_vld = '0;
  logic [31:0] exp_data [2] = '{32'd0, 32'd0};
  logic        exp_err = 1'b0;
  logic        exp_ready = 1'b0;
  logic        chk_en = 1'b0;

  function automatic int popc(input logic [23:0] v);
    int n = 0;
    for (int i = 0; i < 24; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic int bitpos(input logic [23:0] v);
    for (int i = 0; i < 24; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] mread(input int k);
    int b;
    if (k < 8)  return m[k];
    if (k < 16) return m[k-8] & 32'h0000_FFFF;
    b = k - 16;
    if (b < 4)  return m[b] & 32'h0000_00FF;
    return (m[b-4] >> 8) & 32'h0000_00FF;
  endfunction

  task automatic mwrite(input int k, input logic [31:0] d);
    int b;
    if (k < 8) m[k] = d;
    else if (k < 16) m[k-8] = (m[k-8] & 32'hFFFF_0000) | (d & 32'h0000_FFFF);
    else begin
      b = k - 16;
      if (b < 4) m[b] = (m[b] & 32'hFFFF_FF00) | (d & 32'h0000_00FF);
      else m[b-4] = (m[b-4] & 32'hFFFF_00FF) | ((d & 32'h0000_00FF) << 8);
    end
  endtask

  always @(posedge clock) begin
    logic acc, werr, rerr;
    logic [23:0] ws, rs;
    if (reset) begin
      for (int i = 0; i < 8; i++) m[i] = 32'd0;
      m[2] = 32'h0000_0303;
      exp_vld = '0;
      exp_data[0] = 32'd0;
      exp_data[1] = 32'd0;
      exp_err = 1'b0;
      exp_ready = 1'b0;
      chk_en = 1'b1;
    end else begin
      ws = wr_sel;
      acc = wr_valid && exp_ready;
      werr = acc && (popc(ws) != 1);
      if (acc && popc(ws) == 1) mwrite(bitpos(ws), wr_data);
      rerr = 1'b0;
      for (int p = 0; p < 2; p++) begin
        rs = rd_sel[p];
        if (rd_valid[p]) begin
          exp_vld[p] = 1'b1;
          if (popc(rs) == 1) exp_data[p] = mread(bitpos(rs));
          else begin
            exp_data[p] = 32'd0;
            rerr = 1'b1;
          end
        end else exp_vld[p] = 1'b0;
      end
      exp_err = werr || rerr;
      exp_ready = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("wr_ready", {31'd0, wr_ready}, {31'd0, exp_ready && !reset});
      check("rd_data_valid", {30'd0, rd_data_valid}, {30'd0, exp_vld});
      check("rd_data0", rd_data[0], exp_data[0]);
      check("rd_data1", rd_data[1], exp_data[1]);
      check("select_error", {31'd0, select_error}, {31'd0, exp_err});
    end
  end

  function automatic logic [23:0] fsd(input int n); return 24'h1 << n; endfunction
  function automatic logic [23:0] fsw(input int n); return 24'h1 << (8 + n); endfunction
  function automatic logic [23:0] fsb(input int n); return 24'h1 << (16 + n); endfunction

  function automatic logic [23:0] rsel();
    int r = $urandom_range(0, 15);
    if (r == 0) return 24'd0;
    if (r == 1) return 24'($urandom());
    return 24'h1 << $urandom_range(0, 23);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset, then read EDX / EAX
    step(); step();
    reset = 1'b0;
    check("ready_after_reset", {31'd0, wr_ready}, 32'd0);
    rd_valid = 2'b11; rd_sel[0] = reg_select_t'(fsd(2)); rd_sel[1] = reg_select_t'(fsd(0));
    step();
    rd_valid = 2'b00;
    check("t1_valid", {30'd0, rd_data_valid}, 32'd3);
    check("t1_edx", rd_data[0], 32'h0000_0303);
    check("t1_eax", rd_data[1], 32'h0000_0000);
    check("t1_ready", {31'd0, wr_ready}, 32'd1);

    // EAX then AH
    wr_valid = 1'b1; wr_sel = reg_select_t'(fsd(0)); wr_data = 32'h1234_5678; step();
    wr_sel = reg_select_t'(fsb(4)); wr_data = 32'h0000_00AB; step();
    wr_valid = 1'b0;
    rd_valid = 2'b11; rd_sel[0] = reg_select_t'(fsd(0)); rd_sel[1] = reg_select_t'(fsb(4));
    step();
    rd_valid = 2'b00;
    check("t2_eax", rd_data[0], 32'h1234_AB78);
    check("t2_ah", rd_data[1], 32'h0000_00AB);

    // Same-cycle CX write and ECX read
    wr_valid = 1'b1; wr_sel = reg_select_t'(fsd(1)); wr_data = 32'hFFFF_FFFF; step();
    wr_sel = reg_select_t'(fsw(1)); wr_data = 32'h0000_BEEF;
    rd_valid = 2'b01; rd_sel[0] = reg_select_t'(fsd(1));
    step();
    wr_valid = 1'b0; rd_valid = 2'b00;
    check("t3_bypass_ecx", rd_data[0], 32'hFFFF_BEEF);

    // Bad write selects
    wr_valid = 1'b1; wr_sel = '0; wr_data = 32'hDEAD_BEEF; step();
    wr_valid = 1'b0;
    check("t4_err_zero_sel", {31'd0, select_error}, 32'd1);
    step();
    check("t4_err_clear", {31'd0, select_error}, 32'd0);
    wr_valid = 1'b1; wr_sel = reg_select_t'(fsb(0) | fsw(0)); step();
    wr_valid = 1'b0;
    check("t4_err_two_hot", {31'd0, select_error}, 32'd1);
    rd_valid = 2'b01; rd_sel[0] = reg_select_t'(fsd(0)); step();
    rd_valid = 2'b00;
    check("t4_err_single_pulse", {31'd0, select_error}, 32'd0);
    check("t4_eax_unchanged", rd_data[0], 32'h1234_AB78);

    // Reset cancels a pending response
    wr_valid = 1'b1; wr_sel = reg_select_t'(fsd(2)); wr_data = 32'd0; step();
    wr_valid = 1'b0;
    rd_valid = 2'b01; rd_sel[0] = reg_select_t'(fsd(2)); step();
    rd_valid = 2'b00;
    check("t5_pending", {30'd0, rd_data_valid}, 32'd1);
    reset = 1'b1; step();
    reset = 1'b0;
    check("t5_cancelled", {30'd0, rd_data_valid}, 32'd0);
    step();
    rd_valid = 2'b01; rd_sel[0] = reg_select_t'(fsd(2)); step();
    rd_valid = 2'b00;
    check("t5_edx_reset", rd_data[0], 32'h0000_0303);

    // Sweep every select over all-ones registers
    for (int k = 0; k < 24; k++) begin
      wr_valid = 1'b1; wr_data = 32'hFFFF_FFFF;
      for (int g = 0; g < 8; g++) begin
        wr_sel = reg_select_t'(fsd(g)); step();
      end
      wr_sel = reg_select_t'(fsd(k)); wr_data = 32'hA5A5_5AA5; step();
      wr_valid = 1'b0;
      for (int g = 0; g < 4; g++) begin
        rd_valid = 2'b11;
        rd_sel[0] = reg_select_t'(fsd(2 * g)); rd_sel[1] = reg_select_t'(fsd(2 * g + 1));
        step();
        if (k == 20 && g == 0) check("t6_ah_lane", rd_data[0], 32'hFFFF_A5FF);
      end
      rd_valid = 2'b00;
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      wr_valid = 1'($urandom_range(0, 1));
      wr_sel = reg_select_t'(rsel());
      wr_data = $urandom();
      rd_valid = 2'($urandom_range(0, 3));
      rd_sel[0] = reg_select_t'(rsel());
      rd_sel[1] = reg_select_t'(rsel());
      step();
    end
    reset = 1'b0; wr_valid = 1'b0; rd_valid = 2'b00;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
